// File: rtl/fsk_tx_sched.sv
// Transmit word scheduler: round-robin shares one FSK modulator between two
// requesters and holds each word (or IDLE_WORD filler) for one word period.
module fsk_tx_sched #(
  parameter int               WIDTH      = 16,
  parameter int               BIT_CYCLES = 16,
  parameter logic [WIDTH-1:0] IDLE_WORD  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [WIDTH-1:0] mod_data,
  output logic             mod_start,
  output logic             mod_idle,
  output logic             grant_id,
  output logic             busy,
  output logic [15:0]      word_count
);

  localparam int WORD_CYCLES = WIDTH * BIT_CYCLES;
  localparam int CW = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last_grant;
  logic            boundary;
  logic            win_any;
  logic            win_id;

  // Handshake: a requester holds valid and data stable until it sees ready.
  // Ready is a single-cycle acceptance, only ever raised in a slot boundary
  // cycle, so the word is consumed on the same edge that loads mod_data.
  always_comb begin
    boundary = enable && ((state == IDLE) || (cnt == LAST));
    win_any  = req0_valid || req1_valid;
    win_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  end

  assign req0_ready = boundary && !rst && win_any && !win_id;
  assign req1_ready = boundary && !rst && win_any && win_id;
  assign busy       = (state == SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mod_data   <= IDLE_WORD;
      mod_start  <= 1'b0;
      mod_idle   <= 1'b1;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      word_count <= 16'd0;
    end else begin
      mod_start <= 1'b0;
      if (boundary) begin
        mod_start <= 1'b1;
        cnt       <= '0;
        state     <= SEND;
        if (win_any) begin
          mod_data   <= win_id ? req1_data : req0_data;
          grant_id   <= win_id;
          last_grant <= win_id;
          mod_idle   <= 1'b0;
          word_count <= word_count + 16'd1;
        end else begin
          mod_data <= IDLE_WORD;
          mod_idle <= 1'b1;
        end
      end else if (state == SEND) begin
        // Disabled at the last cycle of a word: park without a new slot.
        if (cnt == LAST) begin
          state    <= IDLE;
          mod_data <= IDLE_WORD;
          mod_idle <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fsk_tx_sched.sv
// Directed bench for fsk_tx_sched: a slot table plus hand sequences for
// enable drop, mid-word reset and word_count wrap.
module tb_fsk_tx_sched;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [15:0] mod_data;
  logic        mod_start, mod_idle, grant_id, busy;
  logic [15:0] word_count;

  // Second instance with a one-cycle word period to reach the counter wrap.
  logic        w_rst, w_enable, w_req0_valid, w_req1_valid;
  logic [0:0]  w_req0_data, w_req1_data, w_mod_data;
  logic        w_req0_ready, w_req1_ready, w_mod_start, w_mod_idle;
  logic        w_grant_id, w_busy;
  logic [15:0] w_word_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v0;
    logic [15:0] d0;
    logic        v1;
    logic [15:0] d1;
    logic        r0;
    logic        r1;
    logic [15:0] data;
    logic        idle;
    logic        gid;
    logic [15:0] wc;
  } slot_t;

  slot_t tbl[9];

  fsk_tx_sched dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .mod_data(mod_data), .mod_start(mod_start), .mod_idle(mod_idle),
    .grant_id(grant_id), .busy(busy), .word_count(word_count)
  );

  fsk_tx_sched #(.WIDTH(1), .BIT_CYCLES(1), .IDLE_WORD(1'b0)) dut_wrap (
    .clk(clk), .rst(w_rst), .enable(w_enable),
    .req0_valid(w_req0_valid), .req0_data(w_req0_data), .req0_ready(w_req0_ready),
    .req1_valid(w_req1_valid), .req1_data(w_req1_data), .req1_ready(w_req1_ready),
    .mod_data(w_mod_data), .mod_start(w_mod_start), .mod_idle(w_mod_idle),
    .grant_id(w_grant_id), .busy(w_busy), .word_count(w_word_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered in a boundary cycle; leaves in the next boundary cycle.
  task automatic run_slot(input int idx, input slot_t s);
    int bad;
    req0_valid = s.v0; req0_data = s.d0;
    req1_valid = s.v1; req1_data = s.d1;
    #1;
    chk($sformatf("slot%0d req0_ready", idx), req0_ready, s.r0);
    chk($sformatf("slot%0d req1_ready", idx), req1_ready, s.r1);
    tick();
    if (s.r0) req0_valid = 1'b0;
    if (s.r1) req1_valid = 1'b0;
    chk($sformatf("slot%0d mod_start", idx), mod_start, 1'b1);
    chk($sformatf("slot%0d mod_data", idx), mod_data, s.data);
    chk($sformatf("slot%0d mod_idle", idx), mod_idle, s.idle);
    chk($sformatf("slot%0d grant_id", idx), grant_id, s.gid);
    chk($sformatf("slot%0d word_count", idx), word_count, s.wc);
    chk($sformatf("slot%0d busy", idx), busy, 1'b1);
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (mod_data !== s.data || mod_start !== 1'b0 || busy !== 1'b1) bad++;
      if (i < 255 && (req0_ready !== 1'b0 || req1_ready !== 1'b0)) bad++;
    end
    chk($sformatf("slot%0d hold", idx), bad, 0);
  endtask

  initial begin
    int bad;
    tbl[0] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'd1};
    tbl[3] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 16'd2};
    tbl[4] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'd3};
    tbl[5] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 16'd4};
    tbl[6] = '{1'b1, 16'h1111, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'd5};
    tbl[7] = '{1'b1, 16'hA5C3, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hA5C3, 1'b0, 1'b0, 16'd6};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd6};

    w_rst = 1'b1; w_enable = 1'b0; w_req0_valid = 1'b0; w_req0_data = 1'b1;
    w_req1_valid = 1'b0; w_req1_data = 1'b0;

    // Reset with requesters already pending: no ready may escape.
    rst = 1'b1; enable = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h9999;
    req1_valid = 1'b1; req1_data = 16'h8888;
    tick();
    chk("rst req0_ready", req0_ready, 1'b0);
    chk("rst req1_ready", req1_ready, 1'b0);
    tick();
    chk("rst mod_data", mod_data, 16'h0000);
    chk("rst mod_idle", mod_idle, 1'b1);
    chk("rst mod_start", mod_start, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst grant_id", grant_id, 1'b0);
    chk("rst word_count", word_count, 16'd0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    for (int k = 0; k < 9; k++) run_slot(k, tbl[k]);

    // Enable dropped at cnt=100 of a BEEF slot.
    req1_valid = 1'b1; req1_data = 16'hBEEF;
    #1;
    chk("beef req1_ready", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    chk("beef mod_data", mod_data, 16'hBEEF);
    chk("beef grant_id", grant_id, 1'b1);
    chk("beef word_count", word_count, 16'd7);
    repeat (100) tick();
    enable = 1'b0;
    repeat (155) tick();
    chk("beef held to end", mod_data, 16'hBEEF);
    chk("beef busy at end", busy, 1'b1);
    req1_valid = 1'b1; req1_data = 16'h7777;
    #1;
    chk("disabled req1_ready", req1_ready, 1'b0);
    tick();
    chk("disabled mod_data", mod_data, 16'h0000);
    chk("disabled busy", busy, 1'b0);
    chk("disabled mod_start", mod_start, 1'b0);
    chk("disabled mod_idle", mod_idle, 1'b1);
    chk("disabled grant_id", grant_id, 1'b1);
    bad = 0;
    repeat (5) begin
      tick();
      if (req1_ready !== 1'b0 || mod_start !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("disabled quiet", bad, 0);
    enable = 1'b1;
    #1;
    chk("reenable req1_ready", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    chk("reenable mod_start", mod_start, 1'b1);
    chk("reenable mod_data", mod_data, 16'h7777);
    chk("reenable word_count", word_count, 16'd8);
    repeat (255) tick();
    req0_valid = 1'b1; req0_data = 16'h5555;
    #1;
    chk("r0 word req0_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    chk("r0 word mod_data", mod_data, 16'h5555);
    chk("r0 word grant_id", grant_id, 1'b0);
    chk("r0 word word_count", word_count, 16'd9);

    // Reset at cnt=50 while both requesters wait.
    repeat (50) tick();
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h3333;
    req1_valid = 1'b1; req1_data = 16'h4444;
    #1;
    chk("midrst req0_ready", req0_ready, 1'b0);
    chk("midrst req1_ready", req1_ready, 1'b0);
    tick();
    chk("midrst mod_data", mod_data, 16'h0000);
    chk("midrst busy", busy, 1'b0);
    chk("midrst word_count", word_count, 16'd0);
    chk("midrst mod_idle", mod_idle, 1'b1);
    chk("midrst ready held", {req0_ready, req1_ready}, 2'b00);
    tick();
    rst = 1'b0;
    #1;
    chk("tie req0_ready", req0_ready, 1'b1);
    chk("tie req1_ready", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    chk("tie mod_data", mod_data, 16'h3333);
    chk("tie grant_id", grant_id, 1'b0);
    chk("tie word_count", word_count, 16'd1);
    chk("tie mod_start", mod_start, 1'b1);

    // Counter wrap on the one-cycle-per-word instance.
    w_enable = 1'b1; w_req0_valid = 1'b1;
    tick();
    tick();
    chk("wrap rst word_count", w_word_count, 16'd0);
    w_rst = 1'b0;
    repeat (65535) tick();
    chk("wrap at ffff", w_word_count, 16'hFFFF);
    tick();
    chk("wrap to 0000", w_word_count, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsk_tx_sched.md
Name: fsk_tx_sched

Overview:
Transmit-side word scheduler for the FSK link.
- Shares the single FSK modulator between two word requesters using round-robin arbitration.
- Drives the modulator's parallel data input and holds each word stable for exactly one word period, WIDTH*BIT_CYCLES clocks.
- Fills empty word slots with IDLE_WORD so the modulator and receiver never see undefined data.

Parameters:
WIDTH, 16, word width in bits; equals the modulator data_in width.
BIT_CYCLES, 16, clk cycles per transmitted bit; word period WORD_CYCLES = WIDTH*BIT_CYCLES (256 at defaults).
IDLE_WORD, 16'h0000, filler word sent when no request is granted or the block is disabled.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  scheduler enable
req0_valid  in  1  requester 0 has a word
req0_data  in  WIDTH  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle
req1_valid  in  1  requester 1 has a word
req1_data  in  WIDTH  requester 1 word
req1_ready  out  1  requester 1 word accepted this cycle
mod_data  out  WIDTH  word to modulator data_in (registered)
mod_start  out  1  one-cycle pulse: first cycle of a new word slot
mod_idle  out  1  current slot carries IDLE_WORD
grant_id  out  1  source of the current real word (0/1)
busy  out  1  state==SEND
word_count  out  16  count of real words accepted; wraps

Behaviour:
- Reset values, one edge after rst=1:
  - state=IDLE, cnt=0, mod_data=IDLE_WORD, mod_start=0, mod_idle=1.
  - grant_id=0, last_grant=1 (so req0 wins the first tie), word_count=0.
- A reset asserted mid-word abandons the word; no ready is asserted while rst=1.
- States:
  - IDLE: mod_data=IDLE_WORD, cnt held at 0.
  - SEND: cnt counts 0..WORD_CYCLES-1, then wraps.
- Boundary cycle (B): (state==IDLE and enable) or (state==SEND and cnt==WORD_CYCLES-1 and enable).
- Arbitration, combinational, in B only:
  - One valid: that requester wins.
  - Both valid: winner = !last_grant.
  - None valid: no winner.
  - reqN_ready = B and winner==N; at most one ready per cycle. Ready is never asserted outside B.
- On the edge ending B with a winner:
  - mod_data <= winner data, grant_id <= winner, last_grant <= winner.
  - mod_idle <= 0, word_count <= word_count+1, mod_start <= 1.
  - cnt <= 0, state <= SEND.
- On the edge ending B with no winner:
  - mod_data <= IDLE_WORD, mod_idle <= 1, mod_start <= 1.
  - cnt <= 0, state <= SEND; grant_id and last_grant hold.
- mod_start is high for exactly one cycle after every B edge, otherwise 0.
- Latency: mod_data changes on the B edge; each word is held exactly WORD_CYCLES clocks.
- Enable deasserted mid-word: the current word completes (cnt runs to WORD_CYCLES-1). At that final cycle with enable=0, the next edge sets state <= IDLE, mod_data <= IDLE_WORD, mod_idle <= 1, cnt <= 0, with no ready and no mod_start.
- Enable re-asserted in IDLE: B occurs in that same cycle, so a new slot starts on the next edge.
- Requester contract: valid/data stay stable until ready. A valid deasserted before B is simply not considered.
- word_count wraps 16'hFFFF -> 16'h0000. grant_id is not updated for idle slots.

Test Plan:
1. Reset with defaults, rst=1 for 2 cycles, enable=1, no valids -> mod_data=16'h0000, mod_idle=1, mod_start pulses every 256 cycles, no ready asserted, word_count=0.
2. req0_valid=1, data=16'hA5C3 at IDLE -> req0_ready high 1 cycle; mod_data=16'hA5C3 for exactly 256 cycles; grant_id=0; word_count=1; next slot IDLE_WORD if req0_valid drops.
3. Both valid continuously, req0=16'h1111, req1=16'h2222 -> slots alternate 1111, 2222, 1111, 2222 (req0 first); each ready pulses once per 512 cycles; word_count=4 after 4 slots.
4. enable dropped at cnt=100 of a 16'hBEEF slot -> BEEF held until cnt=255, then mod_data=0000, busy=0, no mod_start; pending req1_valid gets no ready until enable returns.
5. rst asserted at cnt=50 mid-word -> next cycle mod_data=0000, busy=0, word_count=0, no ready during reset; after release and enable, req0 wins a both-valid tie.
6. Preload via 65535 accepted words (or force word_count=16'hFFFF) then accept one more -> word_count=16'h0000.
